// File: rtl/toy_bus_pkg.sv
// rtl/toy_bus_pkg.sv - ToyBusReq field widths, payload struct and pack/unpack helpers
package toy_bus_pkg;

  localparam int ADDR_W   = 32;
  localparam int STRB_W   = 32;
  localparam int DATA_W   = 256;
  localparam int OPC_W    = 1;
  localparam int SRC_ID_W = 4;
  localparam int TGT_ID_W = 4;
  localparam int SB_W     = 32;

  localparam int REQ_PLD_W = ADDR_W + STRB_W + DATA_W + OPC_W + SRC_ID_W + TGT_ID_W + SB_W;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [STRB_W-1:0]   strb;
    logic [DATA_W-1:0]   data;
    logic [OPC_W-1:0]    opcode;
    logic [SRC_ID_W-1:0] src_id;
    logic [TGT_ID_W-1:0] tgt_id;
    logic [SB_W-1:0]     sideband;
  } toy_bus_req_t;

  function automatic logic [REQ_PLD_W-1:0] pack_req(input toy_bus_req_t r);
    return r;
  endfunction

  function automatic toy_bus_req_t unpack_req(input logic [REQ_PLD_W-1:0] p);
    return toy_bus_req_t'(p);
  endfunction

endpackage

// File: rtl/toy_bus_age_mtx_n.sv
// rtl/toy_bus_age_mtx_n.sv - N-way age matrix: age[i][j]=1 means j is older than i
module toy_bus_age_mtx_n
  import toy_bus_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] upd,
  output logic [WIDTH-1:0] sel
);

  logic [WIDTH-1:0] age [WIDTH];

  // upd is one-hot: the updated channel becomes younger than every other one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++)
        for (int j = 0; j < WIDTH; j++)
          age[i][j] <= (j < i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        for (int j = 0; j < WIDTH; j++)
          if (i != j) begin
            if (upd[i])
              age[i][j] <= 1'b1;
            else if (upd[j])
              age[i][j] <= 1'b0;
          end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < WIDTH; i++)
      sel[i] = req[i] & ~|(age[i] & req);
  end

endmodule

// File: rtl/toy_bus_age_arb_lock.sv
// rtl/toy_bus_age_arb_lock.sv - oldest-first N-input arbiter with packet lock and optional skid output
module toy_bus_age_arb_lock
  import toy_bus_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int PLD_W     = REQ_PLD_W,
  parameter int LOCK_EN   = 1,
  parameter int MAX_BURST = 8,
  parameter int OUT_REG   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IN-1:0]          in_vld,
  output logic [NUM_IN-1:0]          in_rdy,
  input  logic [NUM_IN*PLD_W-1:0]    in_pld,
  input  logic [NUM_IN-1:0]          in_lock,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [PLD_W-1:0]           out_pld,
  output logic [$clog2(NUM_IN)-1:0]  out_src
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(MAX_BURST);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [NUM_IN-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (oh[i])
        idx = idx | IDX_W'(i);
    return idx;
  endfunction

  logic [NUM_IN-1:0] sel, gnt, acc;
  logic [0:0]        state;
  logic [IDX_W-1:0]  lock_idx, gnt_idx, acc_idx;
  logic [CNT_W-1:0]  beat_cnt;
  logic              push_ok, acc_any, acc_lock;
  logic [PLD_W-1:0]  fwd_pld;

  toy_bus_age_mtx_n #(.WIDTH(NUM_IN)) u_age (
    .clk (clk),
    .rst (rst),
    .req (in_vld),
    .upd (acc),
    .sel (sel)
  );

  // While locked the grant is pinned even if the owner is momentarily idle
  always_comb begin
    gnt = '0;
    if (LOCK_EN != 0 && state == ST_LOCKED)
      gnt[lock_idx] = 1'b1;
    else
      gnt = sel;
  end

  assign in_rdy   = rst ? '0 : (gnt & {NUM_IN{push_ok}});
  assign acc      = in_rdy & in_vld;
  assign acc_any  = |acc;
  assign acc_lock = |(acc & in_lock);
  assign acc_idx  = oh2idx(acc);
  assign gnt_idx  = oh2idx(gnt);

  always_comb begin
    fwd_pld = '0;
    for (int i = 0; i < NUM_IN; i++)
      fwd_pld = fwd_pld | (in_pld[i*PLD_W +: PLD_W] & {PLD_W{gnt[i]}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_idx <= '0;
      beat_cnt <= '0;
    end else if (LOCK_EN != 0 && acc_any) begin
      if (state == ST_IDLE) begin
        if (acc_lock) begin
          state    <= ST_LOCKED;
          lock_idx <= acc_idx;
          beat_cnt <= CNT_W'(1);
        end
      end else if (!acc_lock || beat_cnt == CNT_W'(MAX_BURST - 1)) begin
        state    <= ST_IDLE;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : g_comb
      logic gnt_vld;
      assign gnt_vld = |(gnt & in_vld);
      assign push_ok = out_rdy;
      assign out_vld = ~rst & gnt_vld;
      assign out_pld = fwd_pld;
      assign out_src = out_vld ? gnt_idx : '0;
    end else begin : g_skid
      logic [1:0]       cnt;
      logic [PLD_W-1:0] head_pld, skid_pld;
      logic [IDX_W-1:0] head_src, skid_src;
      logic             push, pop;

      // Ready comes only from the occupancy register, never from out_rdy
      assign push_ok = (cnt != 2'd2);
      assign push    = acc_any;
      assign pop     = (cnt != 2'd0) & out_rdy;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt      <= 2'd0;
          head_pld <= '0;
          head_src <= '0;
          skid_pld <= '0;
          skid_src <= '0;
        end else begin
          case (cnt)
            2'd0: if (push) begin
              head_pld <= fwd_pld;
              head_src <= gnt_idx;
              cnt      <= 2'd1;
            end
            2'd1: if (push && pop) begin
              head_pld <= fwd_pld;
              head_src <= gnt_idx;
            end else if (push) begin
              skid_pld <= fwd_pld;
              skid_src <= gnt_idx;
              cnt      <= 2'd2;
            end else if (pop) begin
              cnt <= 2'd0;
            end
            default: if (pop) begin
              head_pld <= skid_pld;
              head_src <= skid_src;
              cnt      <= 2'd1;
            end
          endcase
        end
      end

      assign out_vld = (cnt != 2'd0);
      assign out_pld = head_pld;
      assign out_src = head_src;
    end
  endgenerate

endmodule

// File: tb/tb_toy_bus_age_arb_lock.sv
// tb/tb_toy_bus_age_arb_lock.sv - random and directed bench for toy_bus_age_arb_lock against a queue-based model
module tb_toy_bus_age_arb_lock;
  import toy_bus_pkg::*;

  localparam int PW = REQ_PLD_W;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  logic [3:0]    vld [2];
  logic [3:0]    lck [2];
  logic [3:0]    rdy [2];
  logic          ordy [2];
  logic          ovld [2];
  logic [PW-1:0] opld [2];
  logic [1:0]    osrc [2];
  logic [PW-1:0] pld [2][4];
  logic [4*PW-1:0] fpld [2];

  int n_pass = 0;
  int n_tot  = 0;

  // Model state: channel age list (oldest first), lock, and output queue for the skid instance
  int            ord [2][4];
  bit            lk [2];
  int            lidx [2];
  int            beats [2];
  logic [3:0]    acc [2];
  logic [PW-1:0] fq_pld [$];
  int            fq_src [$];
  logic [PW-1:0] last_pld;

  always #5 clk = ~clk;

  assign fpld[0] = {pld[0][3], pld[0][2], pld[0][1], pld[0][0]};
  assign fpld[1] = {pld[1][3], pld[1][2], pld[1][1], pld[1][0]};

  toy_bus_age_arb_lock #(.NUM_IN(4), .PLD_W(PW), .LOCK_EN(1), .MAX_BURST(MB), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_vld(vld[0]), .in_rdy(rdy[0]), .in_pld(fpld[0]), .in_lock(lck[0]),
    .out_vld(ovld[0]), .out_rdy(ordy[0]), .out_pld(opld[0]), .out_src(osrc[0]));

  toy_bus_age_arb_lock #(.NUM_IN(4), .PLD_W(PW), .LOCK_EN(1), .MAX_BURST(MB), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_vld(vld[1]), .in_rdy(rdy[1]), .in_pld(fpld[1]), .in_lock(lck[1]),
    .out_vld(ovld[1]), .out_rdy(ordy[1]), .out_pld(opld[1]), .out_src(osrc[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    else n_pass++;
  endtask

  task automatic chkp(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    else n_pass++;
  endtask

  function automatic logic [PW-1:0] rand_pld();
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r = {r[PW-33:0], $urandom()};
    return r;
  endfunction

  task automatic model_reset(input int m);
    for (int k = 0; k < 4; k++) ord[m][k] = k;
    lk[m] = 0; lidx[m] = 0; beats[m] = 0; acc[m] = '0;
    if (m == 1) begin
      fq_pld.delete(); fq_src.delete(); last_pld = '0;
    end
  endtask

  function automatic int model_gnt(input int m);
    if (lk[m]) return lidx[m];
    for (int k = 0; k < 4; k++)
      if (vld[m][ord[m][k]]) return ord[m][k];
    return -1;
  endfunction

  task automatic model_accept(input int m, input int a);
    int p;
    p = 0;
    for (int k = 0; k < 4; k++) if (ord[m][k] == a) p = k;
    for (int k = p; k < 3; k++) ord[m][k] = ord[m][k+1];
    ord[m][3] = a;
    if (!lk[m]) begin
      if (lck[m][a]) begin lk[m] = 1; lidx[m] = a; beats[m] = 1; end
    end else begin
      beats[m]++;
      if (!lck[m][a] || beats[m] == MB) lk[m] = 0;
    end
  endtask

  always @(negedge clk) begin
    int g, esrc;
    logic [3:0] erdy;
    logic evld;
    logic [PW-1:0] epld;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        chk($sformatf("rst_rdy%0d", m), int'(rdy[m]), 0);
        chk($sformatf("rst_vld%0d", m), int'(ovld[m]), 0);
        if (m == 1) chkp("rst_pld1", opld[1], '0);
        model_reset(m);
      end else begin
        g = model_gnt(m);
        if (m == 0) begin
          erdy = (g >= 0 && ordy[0]) ? 4'(1 << g) : 4'b0;
          evld = (g >= 0) ? vld[0][g] : 1'b0;
          epld = (g >= 0) ? pld[0][g] : '0;
          esrc = evld ? g : 0;
        end else begin
          erdy = (g >= 0 && fq_pld.size() < 2) ? 4'(1 << g) : 4'b0;
          evld = (fq_pld.size() > 0);
          epld = evld ? fq_pld[0] : last_pld;
          esrc = evld ? fq_src[0] : 0;
        end
        chk($sformatf("in_rdy%0d", m), int'(rdy[m]), int'(erdy));
        chk($sformatf("out_vld%0d", m), int'(ovld[m]), int'(evld));
        chkp($sformatf("out_pld%0d", m), opld[m], epld);
        if (m == 0 || evld) chk($sformatf("out_src%0d", m), int'(osrc[m]), esrc);
        acc[m] = erdy & vld[m];
        if (m == 1 && evld && ordy[1]) begin
          last_pld = fq_pld.pop_front();
          void'(fq_src.pop_front());
        end
        if (acc[m] != 0) begin
          if (m == 1) begin fq_pld.push_back(pld[1][g]); fq_src.push_back(g); end
          model_accept(m, g);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 4; c++)
        if (acc[m][c]) pld[m][c] = rand_pld();
  endtask

  initial begin
    int sum;
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      vld[m] = '0; lck[m] = '0; ordy[m] = 1'b1;
      for (int c = 0; c < 4; c++) pld[m][c] = rand_pld();
    end
    vld[0] = 4'hF;
    repeat (2) @(negedge clk);
    chk("lit_rst_rdy", int'(rdy[0]), 0);
    chk("lit_rst_vld", int'(ovld[0]), 0);
    nxt();
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk($sformatf("lit_order%0d", k), int'(osrc[0]), k % 4); nxt();
    end

    vld[0] = 4'b0100;
    repeat (3) begin @(negedge clk); chk("lit_age_ch2", int'(osrc[0]), 2); nxt(); end
    vld[0] = 4'b0101;
    @(negedge clk); chk("lit_age_first", int'(osrc[0]), 0); nxt();

    vld[0] = 4'b0011; lck[0] = 4'b0010;
    repeat (2) begin
      @(negedge clk); chk("lit_lock_src", int'(osrc[0]), 1); chk("lit_lock_rdy0", int'(rdy[0][0]), 0); nxt();
    end
    vld[0][1] = 1'b0;
    @(negedge clk); chk("lit_gap_vld", int'(ovld[0]), 0); chk("lit_gap_rdy0", int'(rdy[0][0]), 0); nxt();
    vld[0][1] = 1'b1; lck[0][1] = 1'b0;
    @(negedge clk); chk("lit_lock_last", int'(osrc[0]), 1); nxt();
    vld[0] = 4'b0001; lck[0] = '0;
    @(negedge clk); chk("lit_lock_after", int'(osrc[0]), 0); nxt();

    vld[0] = 4'b1001; lck[0] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk($sformatf("lit_burst%0d", k), int'(osrc[0]), 3); nxt();
    end
    @(negedge clk); chk("lit_forced_rel", int'(osrc[0]), 0); nxt();
    @(negedge clk); chk("lit_relock", int'(osrc[0]), 3); nxt();

    rst = 1'b1;
    @(negedge clk); chk("lit_midrst_vld", int'(ovld[0]), 0); nxt();
    rst = 1'b0; vld[0] = 4'hF; lck[0] = '0;
    @(negedge clk); chk("lit_midrst_order", int'(osrc[0]), 0); nxt();

    vld[0] = '0; vld[1] = 4'hF; lck[1] = '0; ordy[1] = 1'b0; sum = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); sum += $countones(rdy[1] & vld[1]);
      if (k == 4) chk("lit_bp_rdy", int'(rdy[1]), 0);
      nxt();
    end
    chk("lit_bp_accepted", sum, 2);
    ordy[1] = 1'b1;
    @(negedge clk); chk("lit_drain0", int'(osrc[1]), 0); nxt();
    @(negedge clk); chk("lit_drain1", int'(osrc[1]), 1); nxt();

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int m = 0; m < 2; m++) begin
        ordy[m] = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < 4; c++)
          if (!vld[m][c] || acc[m][c]) begin
            vld[m][c] = ($urandom_range(0, 3) != 0);
            lck[m][c] = 1'($urandom_range(0, 1));
            pld[m][c] = rand_pld();
          end
      end
      @(negedge clk);
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
